// File: rtl/ad5318_pkg.sv
// Shared types and constants for the AD5318 serial-interface master.
// Holds the controller state encoding, frame field positions and channel addresses.
package ad5318_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_GAP   = 3'd3,
    S_LDAC  = 3'd4
  } state_e;

  localparam int CTRL_BIT = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 12;
  localparam int DATA_MSB = 11;
  localparam int DATA_LSB = 2;

  localparam logic [2:0] CH_A = 3'd0;
  localparam logic [2:0] CH_B = 3'd1;
  localparam logic [2:0] CH_C = 3'd2;
  localparam logic [2:0] CH_D = 3'd3;
  localparam logic [2:0] CH_E = 3'd4;
  localparam logic [2:0] CH_F = 3'd5;
  localparam logic [2:0] CH_G = 3'd6;
  localparam logic [2:0] CH_H = 3'd7;

  // Control commands go out verbatim; data writes pack address and 10-bit code.
  function automatic logic [15:0] build_word(input logic [15:0] data,
                                             input logic [2:0]  addr);
    logic [15:0] w;
    if (data[CTRL_BIT]) begin
      w = data;
    end else begin
      w = '0;
      w[ADDR_MSB:ADDR_LSB] = addr;
      w[DATA_MSB:DATA_LSB] = data[9:0];
    end
    return w;
  endfunction

endpackage

// File: rtl/ad5318_ctrl.sv
// Serial-interface master for the AD5318 octal DAC: one command per handshake
// becomes one SYNC_b/SCLK/DIN frame, with an optional automatic LDAC_b pulse.
module ad5318_ctrl
  import ad5318_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int SYNC_GAP    = 4,
  parameter int AUTO_LDAC   = 0,
  parameter int LDAC_CYCLES = 4
) (
  input  logic        clkin,
  input  logic        rstn,
  output logic        SCLK,
  output logic        DIN,
  output logic        SYNC_b,
  output logic        LDAC_b,
  input  logic [15:0] tdata,
  input  logic [2:0]  tuser,
  input  logic        tvalid,
  output logic        tready,
  output state_e      dbg_state
);

  localparam int HALF  = CLK_DIV / 2;
  localparam int CNT_W = 16;

  state_e             state_q, state_d;
  logic [15:0]        word_q, word_d;
  logic               is_data_q, is_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [3:0]         bit_q, bit_d;
  logic               sclk_q, sclk_d;
  logic               din_q, din_d;
  logic               sync_q, sync_d;
  logic               ldac_q, ldac_d;
  logic               tready_q, tready_d;
  logic [15:0]        cmd_word;
  logic               accept;

  // Handshake: a command is taken on a rising clkin edge where tvalid && tready;
  // tready then drops until the frame, gap and any LDAC pulse are complete, so a
  // tvalid left high afterwards is not seen again until tready returns.
  assign accept   = tvalid && tready_q;
  assign cmd_word = build_word(tdata, tuser);

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    is_data_d = is_data_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_d     = bit_q;
    sclk_d    = sclk_q;
    din_d     = din_q;
    sync_d    = sync_q;
    ldac_d    = ldac_q;
    tready_d  = tready_q;

    case (state_q)
      S_IDLE: begin
        sclk_d   = 1'b1;
        sync_d   = 1'b1;
        ldac_d   = 1'b1;
        tready_d = 1'b1;
        if (accept) begin
          state_d   = S_SETUP;
          word_d    = cmd_word;
          is_data_d = ~tdata[CTRL_BIT];
          tready_d  = 1'b0;
          sync_d    = 1'b0;
          din_d     = cmd_word[15];
          cnt_d     = CNT_W'(HALF - 1);
        end
      end

      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // div_q counts clkin cycles since the current SCLK falling edge.
      S_SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_q == CNT_W'(HALF - 1)) begin
          sclk_d = 1'b1;
          if (bit_q != 4'd15) begin
            din_d  = word_q[14];
            word_d = {word_q[14:0], 1'b0};
          end
        end else if (div_q == CNT_W'(CLK_DIV - 1)) begin
          if (bit_q == 4'd15) begin
            state_d = S_GAP;
            sync_d  = 1'b1;
            din_d   = 1'b0;
            cnt_d   = CNT_W'(SYNC_GAP - 1);
          end else begin
            sclk_d = 1'b0;
            div_d  = '0;
            bit_d  = bit_q + 4'd1;
          end
        end
      end

      S_GAP: begin
        if (cnt_q == '0) begin
          if ((AUTO_LDAC != 0) && is_data_q) begin
            state_d = S_LDAC;
            ldac_d  = 1'b0;
            cnt_d   = CNT_W'(LDAC_CYCLES - 1);
          end else begin
            state_d  = S_IDLE;
            tready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_LDAC: begin
        if (cnt_q == '0) begin
          state_d  = S_IDLE;
          ldac_d   = 1'b1;
          tready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All pins are registered so a reset mid-frame returns them to idle at once.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      is_data_q <= 1'b0;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      sclk_q    <= 1'b1;
      din_q     <= 1'b0;
      sync_q    <= 1'b1;
      ldac_q    <= 1'b1;
      tready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      is_data_q <= is_data_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      sclk_q    <= sclk_d;
      din_q     <= din_d;
      sync_q    <= sync_d;
      ldac_q    <= ldac_d;
      tready_q  <= tready_d;
    end
  end

  assign SCLK      = sclk_q;
  assign DIN       = din_q;
  assign SYNC_b    = sync_q;
  assign LDAC_b    = ldac_q;
  assign tready    = tready_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ad5318_ctrl.sv
// Bench for ad5318_ctrl: a small DAC receiver model decodes frames and checks
// them against a queue of expected words pushed when each command is driven.
`timescale 1ns/1ps
module tb_ad5318_ctrl;
  import ad5318_pkg::*;

  logic        clkin = 1'b0;
  logic        rstn  = 1'b0;
  logic [15:0] tdata = '0;
  logic [2:0]  tuser = '0;
  logic        tvalid = 1'b0;
  logic        SCLK, DIN, SYNC_b, LDAC_b, tready;
  state_e      dbg_state;

  ad5318_ctrl #(
    .CLK_DIV(4), .SYNC_GAP(4), .AUTO_LDAC(0), .LDAC_CYCLES(4)
  ) dut (
    .clkin(clkin), .rstn(rstn), .SCLK(SCLK), .DIN(DIN), .SYNC_b(SYNC_b),
    .LDAC_b(LDAC_b), .tdata(tdata), .tuser(tuser), .tvalid(tvalid),
    .tready(tready), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // scoreboard and DAC receiver model
  logic [15:0] exp_q[$];
  logic [15:0] exp_word;
  logic [15:0] rx_sh = '0;
  int          rx_bits = 0;
  bit          in_frame = 0;
  bit          abort_ok = 0;
  time         t_fall = 0;
  int          frames = 0;
  int          aborts = 0;
  int          ldac_pulses = 0;
  logic [9:0]  dac_reg [8];

  always @(negedge SYNC_b) begin
    in_frame = 1;
    rx_bits  = 0;
    rx_sh    = '0;
    t_fall   = $time;
  end

  always @(negedge SCLK) begin
    if (in_frame && SYNC_b === 1'b0) begin
      rx_sh = {rx_sh[14:0], DIN};
      rx_bits++;
    end
  end

  always @(posedge SYNC_b) begin
    if (in_frame) begin
      in_frame = 0;
      if (rx_bits == 16) begin
        frames++;
        check_eq("frame_len", 32'(($time - t_fall) / 10), 32'd66);
        check_eq("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          check_eq("frame_word", 32'(rx_sh), 32'(exp_word));
        end
        if (!rx_sh[15]) dac_reg[rx_sh[14:12]] = rx_sh[11:2];
      end else if (abort_ok) begin
        aborts++;
      end else begin
        check_eq("frame_bits", 32'(rx_bits), 32'd16);
      end
    end
  end

  always @(negedge LDAC_b) ldac_pulses++;

  // driver tasks
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (tready !== 1'b1 && n < 400) begin
      @(negedge clkin);
      n++;
    end
    check_eq(tag, 32'(tready), 32'd1);
  endtask

  task automatic send_cmd(input logic [15:0] d, input logic [2:0] u, input logic [15:0] exp_w);
    int f0;
    wait_ready("ready_before");
    f0     = frames;
    tdata  = d;
    tuser  = u;
    tvalid = 1'b1;
    exp_q.push_back(exp_w);
    @(negedge clkin);
    check_eq("tready_drop", 32'(tready), 32'd0);
    // Scramble the bus after acceptance; the frame must carry the captured word.
    tdata = 16'($urandom);
    tuser = 3'($urandom_range(0, 7));
    repeat (7) @(negedge clkin);
    check_eq("tready_hold", 32'(tready), 32'd0);
    tvalid = 1'b0;
    wait_ready("ready_after");
    check_eq("frame_count", 32'(frames - f0), 32'd1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [2:0]  u;
    int          n;

    for (int i = 0; i < 8; i++) dac_reg[i] = '0;

    // reset values
    #92;
    check_eq("rst_sclk", 32'(SCLK), 32'd1);
    check_eq("rst_din", 32'(DIN), 32'd0);
    check_eq("rst_sync", 32'(SYNC_b), 32'd1);
    check_eq("rst_ldac", 32'(LDAC_b), 32'd1);
    check_eq("rst_tready", 32'(tready), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clkin);
    rstn = 1'b1;
    #1;
    check_eq("tready_pre_edge", 32'(tready), 32'd0);
    @(negedge clkin);
    check_eq("tready_after_rst", 32'(tready), 32'd1);

    // directed commands
    send_cmd(16'h8030, 3'd0, 16'h8030);
    send_cmd(16'hC000, 3'd0, 16'hC000);
    send_cmd(16'h0001, CH_E, 16'h4004);
    check_eq("dac_ch_e", 32'(dac_reg[CH_E]), 32'd1);
    send_cmd(16'hA002, 3'd0, 16'hA002);
    check_eq("no_ldac_pulse", 32'(ldac_pulses), 32'd0);

    // random data writes, including junk in tdata[14:10]
    for (int i = 0; i < 4; i++) begin
      d = 16'($urandom_range(0, 16'h7FFF));
      u = 3'($urandom_range(0, 7));
      send_cmd(d, u, {1'b0, u, d[9:0], 2'b00});
      check_eq("dac_reg_rand", 32'(dac_reg[u]), 32'(d[9:0]));
    end

    // reset in the middle of a frame
    wait_ready("ready_abort");
    tdata  = 16'h8123;
    tuser  = 3'd0;
    tvalid = 1'b1;
    n = 0;
    while (SYNC_b !== 1'b0 && n < 50) begin
      @(negedge clkin);
      n++;
    end
    check_eq("abort_sync_fell", 32'(SYNC_b), 32'd0);
    tvalid = 1'b0;
    repeat (20) @(posedge clkin);
    #3;
    check_eq("abort_in_shift", 32'(dbg_state), 32'(S_SHIFT));
    abort_ok = 1;
    rstn = 1'b0;
    #1;
    check_eq("abort_sync", 32'(SYNC_b), 32'd1);
    check_eq("abort_sclk", 32'(SCLK), 32'd1);
    check_eq("abort_din", 32'(DIN), 32'd0);
    check_eq("abort_tready", 32'(tready), 32'd0);
    check_eq("abort_seen", 32'(aborts), 32'd1);
    #40;
    @(negedge clkin);
    abort_ok = 0;
    rstn = 1'b1;
    send_cmd(16'h8055, 3'd0, 16'h8055);

    repeat (10) @(negedge clkin);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    check_eq("total_frames", 32'(frames), 32'd9);
    check_eq("ldac_final", 32'(ldac_pulses), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
